// File: rtl/acc_adapter.sv
// acc_adapter: core-side bridge from the CPU accelerator X-interface to the
// hierarchical accelerator C-interconnect. The request path is combinational
// (broadcast, predecoder select, address, operand gating). Responses pass
// through a one-entry register that supports a pop and a push in the same cycle.
//
// Handshake rule on every valid/ready pair: a transfer happens on a rising
// clock edge where valid and ready are both high. A source that raises valid
// holds its payload stable until that edge. Ready may depend combinationally
// on the payload, but never on valid.
module acc_adapter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumHier = 3,
  parameter int unsigned NumRsp [NumHier] = '{4, 2, 2},
  localparam int unsigned NumRspTot = sum_rsp(NumHier),
  localparam int unsigned HierAddrWidth = idx_width(NumHier),
  localparam int unsigned AccAddrWidth = idx_width(max_rsp()),
  localparam int unsigned AddrWidth = HierAddrWidth + AccAddrWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  // X request
  input  logic                                x_q_valid_i,
  output logic                                x_q_ready_o,
  input  logic [31:0]                         x_q_instr_data_i,
  input  logic [2:0][DataWidth-1:0]           x_q_rs_i,
  input  logic [2:0]                          x_q_rs_valid_i,
  output logic                                x_k_accept_o,
  output logic                                x_k_writeback_o,
  // X response
  output logic                                x_p_valid_o,
  input  logic                                x_p_ready_i,
  output logic [DataWidth-1:0]                x_p_data_o,
  output logic [4:0]                          x_p_rd_o,
  output logic                                x_p_error_o,
  // C request
  output logic                                c_q_valid_o,
  input  logic                                c_q_ready_i,
  output logic [AddrWidth-1:0]                c_q_addr_o,
  output logic [31:0]                         c_q_instr_data_o,
  output logic [2:0][DataWidth-1:0]           c_q_rs_o,
  output logic                                c_q_id_o,
  // C response
  input  logic                                c_p_valid_i,
  output logic                                c_p_ready_o,
  input  logic [DataWidth-1:0]                c_p_data_i,
  input  logic [4:0]                          c_p_rd_i,
  input  logic                                c_p_error_i,
  input  logic                                c_p_id_i,
  // Predecoders
  output logic [NumRspTot-1:0][31:0]          prd_instr_data_o,
  input  logic [NumRspTot-1:0]                prd_accept_i,
  input  logic [NumRspTot-1:0]                prd_writeback_i,
  input  logic [NumRspTot-1:0][2:0]           prd_use_rs_i
);

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of predecoders in the levels below 'upto' (flat index offset).
  function automatic int unsigned sum_rsp(input int unsigned upto);
    int unsigned s;
    s = 0;
    for (int unsigned l = 0; l < NumHier; l++) begin
      if (l < upto) s += NumRsp[l];
    end
    return s;
  endfunction

  function automatic int unsigned max_rsp();
    int unsigned m;
    m = 1;
    for (int unsigned l = 0; l < NumHier; l++) begin
      if (NumRsp[l] > m) m = NumRsp[l];
    end
    return m;
  endfunction

  // Hierarchical address of every flat predecoder index, fixed at elaboration.
  logic [NumRspTot-1:0][AddrWidth-1:0] addr_tab;

  for (genvar l = 0; l < NumHier; l++) begin : g_lvl
    for (genvar j = 0; j < NumRsp[l]; j++) begin : g_acc
      localparam int unsigned K = sum_rsp(l) + j;
      assign addr_tab[K] = {HierAddrWidth'(l), AccAddrWidth'(j)};
    end
  end

  logic                 sel_any;
  logic [AddrWidth-1:0] sel_addr;
  logic                 sel_wb;
  logic [2:0]           sel_use;
  logic                 operand_ready;

  // Broadcast the instruction word to every predecoder.
  always_comb begin
    prd_instr_data_o = '0;
    for (int k = 0; k < int'(NumRspTot); k++) begin
      prd_instr_data_o[k] = x_q_instr_data_i;
    end
  end

  // Priority select: scanning downwards lets the lowest accepting index win.
  always_comb begin
    sel_any  = 1'b0;
    sel_addr = '0;
    sel_wb   = 1'b0;
    sel_use  = '0;
    for (int k = int'(NumRspTot) - 1; k >= 0; k--) begin
      if (prd_accept_i[k]) begin
        sel_any  = 1'b1;
        sel_addr = addr_tab[k];
        sel_wb   = prd_writeback_i[k];
        sel_use  = prd_use_rs_i[k];
      end
    end
  end

  // Every operand the selected accelerator uses must be valid.
  assign operand_ready = &(~sel_use | x_q_rs_valid_i);

  // Forward only the operands the accelerator uses, zero the rest.
  always_comb begin
    c_q_rs_o = '0;
    for (int i = 0; i < 3; i++) begin
      c_q_rs_o[i] = sel_use[i] ? x_q_rs_i[i] : '0;
    end
  end

  assign c_q_addr_o       = sel_addr;
  assign c_q_instr_data_o = x_q_instr_data_i;
  assign c_q_id_o         = 1'b0;
  assign c_q_valid_o      = x_q_valid_i & sel_any & operand_ready;
  // A rejected request is consumed immediately; an accepted one waits for C.
  assign x_q_ready_o      = sel_any ? (c_q_ready_i & operand_ready) : 1'b1;
  assign x_k_accept_o     = sel_any;
  assign x_k_writeback_o  = sel_any & sel_wb;

  // Response register: single entry, refilled in the cycle it drains.
  logic                 rsp_full;
  logic [DataWidth-1:0] rsp_data;
  logic [4:0]           rsp_rd;
  logic                 rsp_error;
  logic                 rsp_push;
  logic                 rsp_pop;

  assign c_p_ready_o = ~rsp_full | x_p_ready_i;
  assign rsp_push    = c_p_valid_i & c_p_ready_o;
  assign rsp_pop     = rsp_full & x_p_ready_i;

  // Capture on a C handshake, empty on an X handshake without a refill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_full  <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_error <= 1'b0;
    end else if (rsp_push) begin
      rsp_full  <= 1'b1;
      rsp_data  <= c_p_data_i;
      rsp_rd    <= c_p_rd_i;
      rsp_error <= c_p_error_i;
    end else if (rsp_pop) begin
      rsp_full  <= 1'b0;
    end
  end

  assign x_p_valid_o = rsp_full;
  assign x_p_data_o  = rsp_data;
  assign x_p_rd_o    = rsp_rd;
  assign x_p_error_o = rsp_error;

  // Single hart: the response id carries no information.
  logic unused_c_p_id;
  assign unused_c_p_id = c_p_id_i;

endmodule

// File: tb/tb_acc_adapter.sv
// Testbench for acc_adapter: directed scenarios plus randomized request and
// response traffic checked against a behavioural model and a response queue.
module tb_acc_adapter;

  localparam int NUM_RSP [3] = '{4, 2, 2};

  logic              clk_i;
  logic              rst_ni;
  logic              x_q_valid_i;
  logic              x_q_ready_o;
  logic [31:0]       x_q_instr_data_i;
  logic [2:0][31:0]  x_q_rs_i;
  logic [2:0]        x_q_rs_valid_i;
  logic              x_k_accept_o;
  logic              x_k_writeback_o;
  logic              x_p_valid_o;
  logic              x_p_ready_i;
  logic [31:0]       x_p_data_o;
  logic [4:0]        x_p_rd_o;
  logic              x_p_error_o;
  logic              c_q_valid_o;
  logic              c_q_ready_i;
  logic [3:0]        c_q_addr_o;
  logic [31:0]       c_q_instr_data_o;
  logic [2:0][31:0]  c_q_rs_o;
  logic              c_q_id_o;
  logic              c_p_valid_i;
  logic              c_p_ready_o;
  logic [31:0]       c_p_data_i;
  logic [4:0]        c_p_rd_i;
  logic              c_p_error_i;
  logic              c_p_id_i;
  logic [7:0][31:0]  prd_instr_data_o;
  logic [7:0]        prd_accept_i;
  logic [7:0]        prd_writeback_i;
  logic [7:0][2:0]   prd_use_rs_i;

  int checks = 0;
  int errors = 0;

  acc_adapter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .x_q_valid_i(x_q_valid_i), .x_q_ready_o(x_q_ready_o),
    .x_q_instr_data_i(x_q_instr_data_i), .x_q_rs_i(x_q_rs_i),
    .x_q_rs_valid_i(x_q_rs_valid_i),
    .x_k_accept_o(x_k_accept_o), .x_k_writeback_o(x_k_writeback_o),
    .x_p_valid_o(x_p_valid_o), .x_p_ready_i(x_p_ready_i),
    .x_p_data_o(x_p_data_o), .x_p_rd_o(x_p_rd_o), .x_p_error_o(x_p_error_o),
    .c_q_valid_o(c_q_valid_o), .c_q_ready_i(c_q_ready_i),
    .c_q_addr_o(c_q_addr_o), .c_q_instr_data_o(c_q_instr_data_o),
    .c_q_rs_o(c_q_rs_o), .c_q_id_o(c_q_id_o),
    .c_p_valid_i(c_p_valid_i), .c_p_ready_o(c_p_ready_o),
    .c_p_data_i(c_p_data_i), .c_p_rd_i(c_p_rd_i),
    .c_p_error_i(c_p_error_i), .c_p_id_i(c_p_id_i),
    .prd_instr_data_o(prd_instr_data_o), .prd_accept_i(prd_accept_i),
    .prd_writeback_i(prd_writeback_i), .prd_use_rs_i(prd_use_rs_i)
  );

  // Clock and watchdog
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model of the request path, from the selection/address rules.
  typedef struct packed {
    logic             acc;
    logic             wb;
    logic             cv;
    logic             xr;
    logic [3:0]       addr;
    logic [2:0][31:0] rs;
  } req_exp_t;

  function automatic req_exp_t model_req();
    req_exp_t e;
    int k, l, j;
    logic rdy;
    e = '0;
    e.xr = 1'b1;
    k = -1;
    for (int i = 0; i < 8; i++) begin
      if (prd_accept_i[i] && k < 0) k = i;
    end
    if (k >= 0) begin
      l = 0;
      j = k;
      while (j >= NUM_RSP[l]) begin
        j -= NUM_RSP[l];
        l++;
      end
      e.acc  = 1'b1;
      e.wb   = prd_writeback_i[k];
      e.addr = 4'(l * 4 + j);
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (prd_use_rs_i[k][i]) begin
          e.rs[i] = x_q_rs_i[i];
          if (!x_q_rs_valid_i[i]) rdy = 1'b0;
        end
      end
      e.cv = x_q_valid_i & rdy;
      e.xr = c_q_ready_i & rdy;
    end
    return e;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    x_q_valid_i      = 1'b0;
    x_q_instr_data_i = '0;
    x_q_rs_i         = '0;
    x_q_rs_valid_i   = '0;
    x_p_ready_i      = 1'b0;
    c_q_ready_i      = 1'b0;
    c_p_valid_i      = 1'b0;
    c_p_data_i       = '0;
    c_p_rd_i         = '0;
    c_p_error_i      = 1'b0;
    c_p_id_i         = 1'b0;
    prd_accept_i     = '0;
    prd_writeback_i  = '0;
    prd_use_rs_i     = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    c_p_valid_i = 1'b1;
    c_p_data_i  = 32'h1234_5678;
    #3;
    checks++;
    if (x_p_valid_o !== 1'b0) begin errors++; $display("FAIL reset_x_p_valid got %b exp 0", x_p_valid_o); end
    checks++;
    if ({x_p_data_o, x_p_rd_o, x_p_error_o} !== '0) begin
      errors++; $display("FAIL reset_x_p_payload got %h/%h/%b exp 0", x_p_data_o, x_p_rd_o, x_p_error_o);
    end
    checks++;
    if (c_p_ready_o !== 1'b1) begin errors++; $display("FAIL reset_c_p_ready got %b exp 1", c_p_ready_o); end
    @(posedge clk_i); #1;
    checks++;
    if (x_p_valid_o !== 1'b0) begin errors++; $display("FAIL reset_no_capture got %b exp 0", x_p_valid_o); end
    c_p_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (x_p_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_x_p_valid got %b exp 0", x_p_valid_o); end
  endtask

  task automatic test_reject();
    @(posedge clk_i); #1;
    x_q_valid_i      = 1'b1;
    x_q_instr_data_i = $urandom;
    prd_accept_i     = '0;
    prd_writeback_i  = 8'hFF;
    prd_use_rs_i     = '1;
    c_q_ready_i      = 1'b0;
    #1;
    checks++;
    if ({x_q_ready_o, x_k_accept_o, x_k_writeback_o, c_q_valid_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reject got ready=%b accept=%b wb=%b cvalid=%b exp 1/0/0/0",
               x_q_ready_o, x_k_accept_o, x_k_writeback_o, c_q_valid_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  task automatic test_addr_map();
    int ks   [6] = '{0, 3, 4, 5, 6, 7};
    int exps [6] = '{0, 3, 4, 5, 8, 9};
    logic ok;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk_i); #1;
      x_q_valid_i      = 1'b1;
      x_q_instr_data_i = 32'hDEAD_BEEF;
      x_q_rs_valid_i   = 3'b111;
      prd_use_rs_i     = '1;
      prd_accept_i     = 8'(1 << ks[n]);
      c_q_ready_i      = 1'b1;
      #1;
      checks++;
      if (c_q_addr_o !== 4'(exps[n])) begin
        errors++; $display("FAIL addr_k%0d got %h exp %h", ks[n], c_q_addr_o, 4'(exps[n]));
      end
      checks++;
      if (c_q_instr_data_o !== 32'hDEAD_BEEF || c_q_valid_o !== 1'b1 || x_k_accept_o !== 1'b1 || c_q_id_o !== 1'b0) begin
        errors++;
        $display("FAIL fwd_k%0d got instr=%h cvalid=%b accept=%b id=%b exp deadbeef/1/1/0",
                 ks[n], c_q_instr_data_o, c_q_valid_o, x_k_accept_o, c_q_id_o);
      end
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (prd_instr_data_o[i] !== 32'hDEAD_BEEF) ok = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL broadcast_k%0d got %h exp all deadbeef", ks[n], prd_instr_data_o); end
    end
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  task automatic test_priority();
    @(posedge clk_i); #1;
    x_q_valid_i     = 1'b1;
    x_q_rs_valid_i  = 3'b111;
    prd_accept_i    = 8'b0100_0100;
    prd_writeback_i = 8'b0000_0100;
    c_q_ready_i     = 1'b1;
    #1;
    checks++;
    if (c_q_addr_o !== 4'b0010 || x_k_writeback_o !== 1'b1) begin
      errors++; $display("FAIL priority_wb1 got addr=%h wb=%b exp 2/1", c_q_addr_o, x_k_writeback_o);
    end
    prd_writeback_i = 8'b0100_0000;
    #1;
    checks++;
    if (c_q_addr_o !== 4'b0010 || x_k_writeback_o !== 1'b0) begin
      errors++; $display("FAIL priority_wb0 got addr=%h wb=%b exp 2/0", c_q_addr_o, x_k_writeback_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  task automatic test_operand_gating();
    @(posedge clk_i); #1;
    x_q_valid_i     = 1'b1;
    x_q_rs_i[0]     = 32'h11;
    x_q_rs_i[1]     = 32'h22;
    x_q_rs_i[2]     = 32'h33;
    x_q_rs_valid_i  = 3'b011;
    prd_accept_i    = 8'b0000_0010;
    prd_use_rs_i[1] = 3'b101;
    c_q_ready_i     = 1'b1;
    #1;
    checks++;
    if (c_q_valid_o !== 1'b0 || x_q_ready_o !== 1'b0) begin
      errors++; $display("FAIL operand_wait got cvalid=%b xready=%b exp 0/0", c_q_valid_o, x_q_ready_o);
    end
    @(posedge clk_i); #1;
    x_q_rs_valid_i = 3'b111;
    #1;
    checks++;
    if (c_q_rs_o[0] !== 32'h11 || c_q_rs_o[1] !== 32'h0 || c_q_rs_o[2] !== 32'h33) begin
      errors++; $display("FAIL operand_rs got %h %h %h exp 11 0 33", c_q_rs_o[0], c_q_rs_o[1], c_q_rs_o[2]);
    end
    checks++;
    if (c_q_valid_o !== 1'b1 || x_q_ready_o !== 1'b1) begin
      errors++; $display("FAIL operand_ready got cvalid=%b xready=%b exp 1/1", c_q_valid_o, x_q_ready_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [3:0] addr0;
    @(posedge clk_i); #1;
    x_q_valid_i      = 1'b1;
    x_q_instr_data_i = 32'hA5A5_0001;
    x_q_rs_valid_i   = 3'b111;
    x_q_rs_i[0]      = 32'h77;
    prd_accept_i     = 8'b0000_1000;
    prd_use_rs_i[3]  = 3'b001;
    c_q_ready_i      = 1'b0;
    #1;
    addr0 = c_q_addr_o;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (x_q_ready_o !== 1'b0 || c_q_valid_o !== 1'b1 || c_q_addr_o !== 4'h3 ||
          c_q_addr_o !== addr0 || c_q_rs_o[0] !== 32'h77) begin
        errors++;
        $display("FAIL backpressure_c%0d got xready=%b cvalid=%b addr=%h rs0=%h exp 0/1/3/77",
                 c, x_q_ready_o, c_q_valid_o, c_q_addr_o, c_q_rs_o[0]);
      end
      @(posedge clk_i); #2;
    end
    c_q_ready_i = 1'b1;
    #1;
    checks++;
    if (x_q_ready_o !== 1'b1 || c_q_valid_o !== 1'b1) begin
      errors++; $display("FAIL backpressure_release got xready=%b cvalid=%b exp 1/1", x_q_ready_o, c_q_valid_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  task automatic test_random_req();
    req_exp_t e;
    for (int n = 0; n < 300; n++) begin
      x_q_valid_i      = 1'($urandom_range(0, 1));
      x_q_instr_data_i = $urandom;
      for (int i = 0; i < 3; i++) x_q_rs_i[i] = $urandom;
      x_q_rs_valid_i   = 3'($urandom);
      prd_accept_i     = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      prd_writeback_i  = 8'($urandom);
      prd_use_rs_i     = 24'($urandom);
      c_q_ready_i      = 1'($urandom_range(0, 1));
      #1;
      e = model_req();
      checks++;
      if ({x_k_accept_o, x_k_writeback_o, c_q_valid_o, x_q_ready_o} !== {e.acc, e.wb, e.cv, e.xr}) begin
        errors++;
        $display("FAIL rand_req_ctl n=%0d got acc/wb/cv/xr=%b%b%b%b exp %b%b%b%b", n,
                 x_k_accept_o, x_k_writeback_o, c_q_valid_o, x_q_ready_o, e.acc, e.wb, e.cv, e.xr);
      end
      if (e.acc) begin
        checks++;
        if (c_q_addr_o !== e.addr || c_q_rs_o !== e.rs || c_q_instr_data_o !== x_q_instr_data_i) begin
          errors++;
          $display("FAIL rand_req_data n=%0d got addr=%h rs=%h exp addr=%h rs=%h", n, c_q_addr_o, c_q_rs_o, e.addr, e.rs);
        end
      end
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_response();
    @(posedge clk_i); #1;
    x_p_ready_i = 1'b0;
    c_p_valid_i = 1'b1;
    c_p_data_i  = 32'hCAFE;
    c_p_rd_i    = 5'd7;
    c_p_error_i = 1'b0;
    @(posedge clk_i); #1;
    c_p_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (x_p_valid_o !== 1'b1 || x_p_data_o !== 32'hCAFE || x_p_rd_o !== 5'd7 ||
          x_p_error_o !== 1'b0 || c_p_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold_c%0d got v=%b d=%h rd=%0d e=%b crdy=%b exp 1/cafe/7/0/0",
                 c, x_p_valid_o, x_p_data_o, x_p_rd_o, x_p_error_o, c_p_ready_o);
      end
      @(posedge clk_i); #1;
    end
    x_p_ready_i = 1'b1;
    #1;
    checks++;
    if (c_p_ready_o !== 1'b1) begin errors++; $display("FAIL rsp_ready_on_pop got %b exp 1", c_p_ready_o); end
    @(posedge clk_i); #1;
    checks++;
    if (x_p_valid_o !== 1'b0) begin errors++; $display("FAIL rsp_drained got %b exp 0", x_p_valid_o); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [37:0] prev;
    x_p_ready_i = 1'b1;
    prev = '0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk_i); #1;
      if (n > 0) begin
        checks++;
        if (x_p_valid_o !== 1'b1 || {x_p_error_o, x_p_rd_o, x_p_data_o} !== prev) begin
          errors++;
          $display("FAIL b2b_n%0d got v=%b %h exp 1 %h", n, x_p_valid_o, {x_p_error_o, x_p_rd_o, x_p_data_o}, prev);
        end
      end
      c_p_valid_i = 1'b1;
      c_p_data_i  = $urandom;
      c_p_rd_i    = 5'($urandom);
      c_p_error_i = 1'($urandom);
      prev = {c_p_error_i, c_p_rd_i, c_p_data_i};
      #1;
      checks++;
      if (c_p_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_n%0d got %b exp 1", n, c_p_ready_o); end
    end
    @(posedge clk_i); #1;
    c_p_valid_i = 1'b0;
    checks++;
    if (x_p_valid_o !== 1'b1 || {x_p_error_o, x_p_rd_o, x_p_data_o} !== prev) begin
      errors++; $display("FAIL b2b_last got %h exp %h", {x_p_error_o, x_p_rd_o, x_p_data_o}, prev);
    end
    @(posedge clk_i); #1;
    checks++;
    if (x_p_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", x_p_valid_o); end
    idle_inputs();
  endtask

  // Scoreboard: the adapter is a one-deep FIFO, modelled as a queue.
  task automatic test_random_rsp();
    logic [37:0] exp_q[$];
    logic [37:0] exp_v;
    logic        pend, m_ready;
    int          accepted, cyc, sz;
    accepted = 0;
    cyc = 0;
    pend = 1'b0;
    while (accepted < 1000 && cyc < 6000) begin
      @(posedge clk_i); #1;
      cyc++;
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend        = 1'b1;
        c_p_data_i  = $urandom;
        c_p_rd_i    = 5'($urandom);
        c_p_error_i = 1'($urandom);
      end
      c_p_valid_i = pend;
      c_p_id_i    = 1'($urandom);
      x_p_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      sz = exp_q.size();
      m_ready = (sz == 0) || x_p_ready_i;
      checks++;
      if (x_p_valid_o !== (sz != 0) || c_p_ready_o !== m_ready) begin
        errors++;
        $display("FAIL rand_rsp_ctl cyc=%0d got v=%b crdy=%b exp %b/%b", cyc, x_p_valid_o, c_p_ready_o, sz != 0, m_ready);
      end
      if (sz != 0 && x_p_ready_i) begin
        exp_v = exp_q.pop_front();
        checks++;
        if ({x_p_error_o, x_p_rd_o, x_p_data_o} !== exp_v) begin
          errors++; $display("FAIL rand_rsp_data cyc=%0d got %h exp %h", cyc, {x_p_error_o, x_p_rd_o, x_p_data_o}, exp_v);
        end
      end
      if (pend && m_ready) begin
        exp_q.push_back({c_p_error_i, c_p_rd_i, c_p_data_i});
        accepted++;
        pend = 1'b0;
      end
    end
    checks++;
    if (accepted != 1000) begin errors++; $display("FAIL rand_rsp_budget got %0d accepted exp 1000", accepted); end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      @(posedge clk_i); #1;
      cyc++;
      c_p_valid_i = 1'b0;
      x_p_ready_i = 1'b1;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (x_p_valid_o !== 1'b1 || {x_p_error_o, x_p_rd_o, x_p_data_o} !== exp_v) begin
        errors++; $display("FAIL rand_rsp_drain got v=%b %h exp 1 %h", x_p_valid_o, {x_p_error_o, x_p_rd_o, x_p_data_o}, exp_v);
      end
    end
    @(posedge clk_i); #1;
    checks++;
    if (x_p_valid_o !== 1'b0) begin errors++; $display("FAIL rand_rsp_final got %b exp 0", x_p_valid_o); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(posedge clk_i); #1;
    c_p_valid_i = 1'b1;
    c_p_data_i  = 32'hBEEF_0042;
    c_p_rd_i    = 5'd19;
    c_p_error_i = 1'b1;
    @(posedge clk_i); #1;
    c_p_valid_i = 1'b0;
    checks++;
    if (x_p_valid_o !== 1'b1 || x_p_data_o !== 32'hBEEF_0042) begin
      errors++; $display("FAIL mid_reset_held got v=%b d=%h exp 1/beef0042", x_p_valid_o, x_p_data_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (x_p_valid_o !== 1'b0 || {x_p_data_o, x_p_rd_o, x_p_error_o} !== '0 || c_p_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_clear got v=%b d=%h rd=%0d e=%b crdy=%b exp 0/0/0/0/1",
               x_p_valid_o, x_p_data_o, x_p_rd_o, x_p_error_o, c_p_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (x_p_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_after got %b exp 0", x_p_valid_o); end
  endtask

  initial begin
    test_reset();
    test_reject();
    test_addr_map();
    test_priority();
    test_operand_gating();
    test_backpressure();
    test_random_req();
    test_response();
    test_back_to_back();
    test_random_rsp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
